// File: rtl/stream_sink.sv
// rtl/stream_sink.sv - valid/ready stream sink with backpressure, drain FIFO and sequence checker
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   mode          backpressure: 0 always, 1 random (LFSR), 2 duty ON/OFF, 3 stall
//   data, valid   incoming beat from the source
//   ready         sink accepts a beat this cycle (registers only, never from valid)
//   rx_data       last beat drained from the FIFO (held between pops)
//   rx_valid      one-cycle pulse per drained beat
//   level         FIFO occupancy
//   beat_cnt      accepted beats, wrapping
//   err, err_cnt  sticky mismatch flag and saturating mismatch count
//
// Optional: STREAM_SINK_CHECK_EN enables the sequence checker; otherwise err/err_cnt are 0.

module stream_sink #(
   parameter int          DATA_W    = 32,
   parameter int          DEPTH     = 4,
   parameter int          DRAIN_DIV = 1,
   parameter int          ON_CYC    = 2,
   parameter int          OFF_CYC   = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter logic [DATA_W-1:0] SEQ_START = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   mode,
   input  logic [DATA_W-1:0]            data,
   input  logic                         valid,
   output logic                         ready,
   output logic [DATA_W-1:0]            rx_data,
   output logic                         rx_valid,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [31:0]                  beat_cnt,
   output logic                         err,
   output logic [15:0]                  err_cnt
);

   localparam int LVL_W  = $clog2(DEPTH+1);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int DIV_W  = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
   localparam int DUTY_W = $clog2(ON_CYC + OFF_CYC + 1);

   logic [15:0]       lfsr_q, lfsr_d;
   logic              gate_q, gate_d;
   logic [1:0]        mode_q;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic [31:0]       beat_cnt_q, beat_cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] head;
   logic              push, pop, tick;

   assign ready = gate_q & (level_q < LVL_W'(DEPTH));
   assign push  = valid & ready;
   assign tick  = (div_q == DIV_W'(DRAIN_DIV - 1));
   assign pop   = tick & (level_q != '0);
   assign head  = mem_q[rd_ptr_q];

   // Backpressure gate. The LFSR free-runs so random mode picks up mid-sequence.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      gate_d = 1'b0;
      duty_d = duty_q;
      case (mode)
         2'd0: gate_d = 1'b1;
         2'd1: gate_d = lfsr_d[0];
         2'd2: begin
            if (mode_q != 2'd2) begin
               // Entering duty mode: this edge is ON position 0, next is position 1.
               gate_d = 1'b1;
               duty_d = DUTY_W'(1);
            end else begin
               gate_d = (duty_q < DUTY_W'(ON_CYC));
               duty_d = (duty_q == DUTY_W'(ON_CYC + OFF_CYC - 1)) ? '0 : duty_q + DUTY_W'(1);
            end
         end
         default: gate_d = 1'b0;
      endcase
   end

   always_comb begin
      div_d      = tick ? '0 : div_q + DIV_W'(1);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      beat_cnt_d = beat_cnt_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      if (push) begin
         wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         beat_cnt_d = beat_cnt_q + 32'd1;
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         rx_valid_d = 1'b1;
         rx_data_d  = head;
      end
      if (push && !pop)
         level_d = level_q + LVL_W'(1);
      else if (!push && pop)
         level_d = level_q - LVL_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q     <= LFSR_SEED;
         gate_q     <= 1'b0;
         mode_q     <= 2'd0;
         duty_q     <= '0;
         div_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         lfsr_q     <= lfsr_d;
         gate_q     <= gate_d;
         mode_q     <= mode;
         duty_q     <= duty_d;
         div_q      <= div_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Storage needs no reset: pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= data;
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign level    = level_q;
   assign beat_cnt = beat_cnt_q;

`ifdef STREAM_SINK_CHECK_EN
   logic [DATA_W-1:0] exp_q;
   logic              err_q;
   logic [15:0]       err_cnt_q;

   // On a mismatch, resync to the received value so one glitch counts once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q     <= SEQ_START;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else if (pop) begin
         if (head == exp_q) begin
            exp_q <= exp_q + DATA_W'(1);
         end else begin
            err_q <= 1'b1;
            if (err_cnt_q != 16'hFFFF)
               err_cnt_q <= err_cnt_q + 16'd1;
            exp_q <= head + DATA_W'(1);
            $display("stream_sink ERR exp 0x%h got 0x%h", exp_q, head);
         end
      end
   end

   assign err     = err_q;
   assign err_cnt = err_cnt_q;
`else
   assign err     = 1'b0;
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_sink.sv
// tb/tb_stream_sink.sv - table-driven bench for stream_sink

module tb_stream_sink;

`ifdef STREAM_SINK_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: 8-bit data, drain every cycle, duty 2 on / 3 off.
   logic        rst_a, valid_a, ready_a, rx_valid_a, err_a;
   logic [1:0]  mode_a;
   logic [7:0]  data_a, rx_data_a;
   logic [2:0]  level_a;
   logic [31:0] beat_cnt_a;
   logic [15:0] err_cnt_a;

   // DUT B: 32-bit data, drain every 8th cycle.
   logic        rst_b, valid_b, ready_b, rx_valid_b, err_b;
   logic [1:0]  mode_b;
   logic [31:0] data_b, rx_data_b;
   logic [2:0]  level_b;
   logic [31:0] beat_cnt_b;
   logic [15:0] err_cnt_b;

   stream_sink #(.DATA_W(8), .DEPTH(4), .DRAIN_DIV(1), .ON_CYC(2), .OFF_CYC(3)) u_a (
      .clk(clk), .rst(rst_a), .mode(mode_a), .data(data_a), .valid(valid_a),
      .ready(ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .level(level_a),
      .beat_cnt(beat_cnt_a), .err(err_a), .err_cnt(err_cnt_a));

   stream_sink #(.DATA_W(32), .DEPTH(4), .DRAIN_DIV(8)) u_b (
      .clk(clk), .rst(rst_b), .mode(mode_b), .data(data_b), .valid(valid_b),
      .ready(ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .level(level_b),
      .beat_cnt(beat_cnt_b), .err(err_b), .err_cnt(err_cnt_b));

   // Reference LFSR for random mode on DUT A (taps 16,14,13,11).
   logic [15:0] m_lfsr;
   always @(posedge clk or posedge rst_a) begin
      if (rst_a) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   typedef struct {
      logic        rst;
      logic [1:0]  mode;
      logic        valid;
      logic [7:0]  data;
      logic        rdy;
      logic [2:0]  lvl;
      logic        rxv;
      logic [7:0]  rxd;
      logic [31:0] bc;
      logic        err;
      logic [15:0] ecnt;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic r, input int m, input logic v, input int d,
                      input logic rdy, input int lvl, input logic rxv, input int rxd,
                      input int bc, input logic e, input int ec);
      vec_t t;
      t.rst = r; t.mode = 2'(m); t.valid = v; t.data = 8'(d);
      t.rdy = rdy; t.lvl = 3'(lvl); t.rxv = rxv; t.rxd = 8'(rxd); t.bc = 32'(bc);
      t.err = e & CHK; t.ecnt = CHK ? 16'(ec) : 16'h0;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   int  b_rdy [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 1};
   int  b_lvl [9] = '{0, 0, 1, 2, 3, 4, 4, 4, 3};
   int  b_bc  [9] = '{0, 0, 1, 2, 3, 4, 4, 4, 4};
   int  b_rxv [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
   bit  duty_pat [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
   bit  seen;

   initial begin
      rst_a = 1'b1; mode_a = 2'd0; valid_a = 1'b0; data_a = '0;
      rst_b = 1'b1; mode_b = 2'd0; valid_b = 1'b0; data_b = '0;

      // Stream 0..9 in mode 0 (one-cycle drain latency).
      add(0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0);
      add(0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 0);
      for (int k = 2; k <= 10; k++)
         add(0, 0, 1, k - 1,  1, 1, (k >= 3), (k >= 3) ? k - 3 : 0, k - 1,  0, 0);
      add(0, 0, 0, 0,  1, 1, 1, 8, 10,  0, 0);
      add(0, 0, 0, 0,  1, 0, 1, 9, 10,  0, 0);
      add(0, 3, 0, 0,  1, 0, 0, 9, 10,  0, 0);
      // Stall with valid held high.
      for (int k = 0; k < 20; k++)
         add(0, 3, 1, 8'hAA,  0, 0, 0, 9, 10,  0, 0);
      // Duty mode 2 on / 3 off.
      add(0, 2, 0, 0,  0, 0, 0, 9, 10,  0, 0);
      for (int k = 0; k < 10; k++)
         add(0, 2, 0, 0,  duty_pat[k], 0, 0, 9, 10,  0, 0);
      // Reset, then checker sequence 0,1,5,6.
      add(1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
      add(0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 0);
      add(0, 0, 1, 1,  1, 1, 0, 0, 1,  0, 0);
      add(0, 0, 1, 5,  1, 1, 1, 0, 2,  0, 0);
      add(0, 0, 1, 6,  1, 1, 1, 1, 3,  0, 0);
      add(0, 0, 0, 0,  1, 1, 1, 5, 4,  1, 1);
      add(0, 0, 0, 0,  1, 0, 1, 6, 4,  1, 1);
      add(0, 0, 0, 0,  1, 0, 0, 6, 4,  1, 1);

      repeat (3) @(negedge clk);
      #1;
      chk("reset ready",    32'(ready_a),    32'd0);
      chk("reset rx_valid", 32'(rx_valid_a), 32'd0);
      chk("reset rx_data",  32'(rx_data_a),  32'd0);
      chk("reset level",    32'(level_a),    32'd0);
      chk("reset beat_cnt", beat_cnt_a,      32'd0);
      chk("reset err",      32'(err_a),      32'd0);
      chk("reset err_cnt",  32'(err_cnt_a),  32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_a = vecs[i].rst; mode_a = vecs[i].mode;
         valid_a = vecs[i].valid; data_a = vecs[i].data;
         #1;
         chk($sformatf("row%0d ready", i),    32'(ready_a),    32'(vecs[i].rdy));
         chk($sformatf("row%0d level", i),    32'(level_a),    32'(vecs[i].lvl));
         chk($sformatf("row%0d rx_valid", i), 32'(rx_valid_a), 32'(vecs[i].rxv));
         chk($sformatf("row%0d rx_data", i),  32'(rx_data_a),  32'(vecs[i].rxd));
         chk($sformatf("row%0d beat_cnt", i), beat_cnt_a,      vecs[i].bc);
         chk($sformatf("row%0d err", i),      32'(err_a),      32'(vecs[i].err));
         chk($sformatf("row%0d err_cnt", i),  32'(err_cnt_a),  32'(vecs[i].ecnt));
      end

      // Random mode: gate follows the LFSR bit produced at the previous edge.
      @(negedge clk);
      mode_a = 2'd1; valid_a = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rand%0d ready", k), 32'(ready_a), 32'(m_lfsr[0]));
      end

      // DUT B: fill to full with slow drain, then reset with level 3.
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         rst_b = 1'b0; valid_b = 1'b1; data_b = 32'(k - 1);
         #1;
         chk($sformatf("b%0d ready", k),    32'(ready_b),    32'(b_rdy[k]));
         chk($sformatf("b%0d level", k),    32'(level_b),    32'(b_lvl[k]));
         chk($sformatf("b%0d beat_cnt", k), beat_cnt_b,      32'(b_bc[k]));
         chk($sformatf("b%0d rx_valid", k), 32'(rx_valid_b), 32'(b_rxv[k]));
      end
      chk("b first pop data", rx_data_b, 32'd0);
      rst_b = 1'b1;
      #1;
      chk("b rst level",    32'(level_b),    32'd0);
      chk("b rst ready",    32'(ready_b),    32'd0);
      chk("b rst rx_valid", 32'(rx_valid_b), 32'd0);
      chk("b rst beat_cnt", beat_cnt_b,      32'd0);
      repeat (2) @(negedge clk);
      rst_b = 1'b0; valid_b = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("b post%0d rx_valid", k), 32'(rx_valid_b), 32'd0);
         chk($sformatf("b post%0d level", k),    32'(level_b),    32'd0);
      end
      chk("b post ready", 32'(ready_b), 32'd1);
      @(negedge clk);
      valid_b = 1'b1; data_b = 32'h1234;
      @(negedge clk);
      valid_b = 1'b0;
      #1;
      chk("b restart beat_cnt", beat_cnt_b,   32'd1);
      chk("b restart level",    32'(level_b), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (rx_valid_b) seen = 1'b1;
      end
      chk("b drain seen", 32'(seen),  32'd1);
      chk("b drain data", rx_data_b,  32'h1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_sink.md
# stream_sink

Parametrised valid/ready stream sink for simulation benches. It is the next-generation receive endpoint behind any stream source in the design. It applies a selectable backpressure pattern and buffers accepted beats in a small FIFO. Beats drain at a programmable rate, and a sequence checker verifies the drained data and counts errors.

## Interface
Parameters:
- DATA_W, 32, data width in bits (≥1)
- DEPTH, 4, FIFO depth in entries (power of two, ≥2)
- DRAIN_DIV, 1, cycles per drain opportunity (≥1; 1 = every cycle)
- ON_CYC, 2, ready-high cycles in duty mode (≥1)
- OFF_CYC, 2, ready-low cycles in duty mode (≥1)
- LFSR_SEED, 16'hACE1, nonzero reset value of backpressure LFSR
- SEQ_START, 0, first expected data value for checker

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- mode  input  2  backpressure mode: 0 always, 1 random, 2 duty, 3 stall
- data  input  DATA_W  incoming beat
- valid  input  1  source has beat
- ready  output  1  sink accepts beat this cycle
- rx_data  output  DATA_W  beat drained from FIFO
- rx_valid  output  1  one-cycle pulse, rx_data valid
- level  output  $clog2(DEPTH+1)  current FIFO occupancy
- beat_cnt  output  32  total accepted beats, wraps at 2^32
- err  output  1  sticky, set on first sequence mismatch
- err_cnt  output  16  mismatch count, saturates at 16'hFFFF

## Operation
- Gate register gate_q, updated every cycle from mode: 0 → 1; 1 → lfsr[0] (next value); 2 → high for ON_CYC cycles then low for OFF_CYC cycles, repeating; 3 → 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle regardless of mode.
- Duty counter restarts at the start of the ON phase whenever mode changes to 2.
- ready = gate_q & (level < DEPTH). It is combinational from registers only, never from valid.
- Push: valid & ready at posedge writes data at the write pointer and increments beat_cnt.
- Drain tick: divider counter 0..DRAIN_DIV-1, tick at terminal count.
- Pop: on a tick with level > 0, register the head into rx_data and pulse rx_valid for one cycle. With no pop, rx_valid = 0 and rx_data holds its value.
- Simultaneous push and pop: level unchanged; both pointers advance; pointers wrap modulo DEPTH.
- Full FIFO: ready = 0 even if a pop occurs in the same cycle (no bypass).
- Checker compares each popped beat against exp, starting at SEQ_START.
  - On a match, exp ← exp+1.
  - On a mismatch, set err, increment err_cnt (saturating), and resync exp ← popped+1.
  - Arithmetic is modulo 2^DATA_W.

## Timing
- Reset values: ready 0, gate_q 0, rx_valid 0, rx_data 0, level 0, beat_cnt 0, err 0, err_cnt 0, pointers 0, divider 0, lfsr LFSR_SEED, exp SEQ_START.
- ready can first rise in the cycle after rst deasserts (gate_q registered).
- Latency from accept to rx_valid is at least 1 cycle; with an empty FIFO and a tick on the next edge, rx_valid asserts 1 cycle after the accepting edge.
- The err/err_cnt update and rx_valid for the mismatching beat occur in the same cycle.
- Reset mid-stream discards FIFO contents immediately; no rx_valid for discarded beats.
- A mode change takes effect on gate_q at the next edge.

## Configuration
- STREAM_SINK_CHECK_EN defined: checker present as described above, and each mismatch issues $display("stream_sink ERR exp 0x%h got 0x%h").
- STREAM_SINK_CHECK_EN undefined: checker logic and exp register are removed; err is tied to 0 and err_cnt to 0. Drain and counters are unchanged.

## Test plan
- Mode 0, DRAIN_DIV=1: 10 valid beats 0..9 → ready=1 from the 2nd cycle after reset, beat_cnt=10, rx_valid pulses carry 0..9 in order, err=0.
- Mode 3, valid held high for 20 cycles → ready=0 throughout, beat_cnt=0, level=0.
- Mode 0, DEPTH=4, DRAIN_DIV=8, valid continuous → ready falls once level=4, with no push while full. Ready reasserts the cycle after the first pop.
- Mode 2, ON_CYC=2, OFF_CYC=3 → ready repeats the pattern 1,1,0,0,0 while the FIFO is not full.
- Checker: send 0,1,5,6 → err set on the 3rd rx_valid, err_cnt=1, no further errors (resync).
- Assert rst with level=3 → level=0, ready=0 and rx_valid=0 immediately. After release, beat_cnt restarts at 0 and exp is SEQ_START.
